draw_port_arbiter: RTL and testbench

//  Shares the single VGA adapter pixel-write port between drawing requesters (paddle, ball, score/erase).

---
 rtl/pong_draw_pkg.sv | 13 +
 rtl/draw_rr_picker.sv | 24 ++
 rtl/draw_port_arbiter.sv | 105 ++++++++++
 tb/tb_draw_port_arbiter.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/pong_draw_pkg.sv
// pong_draw_pkg: screen geometry, pixel field widths and arbiter state encoding
// Shared by draw_port_arbiter and its testbench; no ports.
package pong_draw_pkg;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W = 8;
    localparam int Y_W = 7;
    localparam int COLOUR_W = 3;
    localparam logic [COLOUR_W-1:0] COLOUR_BLACK = 3'b000;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;
endpackage

// File: rtl/draw_rr_picker.sv
// draw_rr_picker: round-robin search for the first active request after last_owner
// Ports: req (request vector), last_owner (previous owner index),
//        found (any request active), index (chosen requester).
module draw_rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_owner,
    output logic               found,
    output logic [IW-1:0]      index
);
    // Scan from farthest to nearest so the nearest candidate is written last and wins.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[(int'(last_owner) + k) % NUM_REQ]) begin
                found = 1'b1;
                index = IW'((int'(last_owner) + k) % NUM_REQ);
            end
        end
    end
endmodule

// File: rtl/draw_port_arbiter.sv
// draw_port_arbiter: round-robin, burst-limited sharing of the VGA adapter pixel-write port
// Ports: clock, reset (sync, active-high); req/x_in/y_in/colour_in packed per requester;
//        grant (registered one-hot); vga_x/vga_y/vga_colour/vga_plot to the adapter; busy.
// Build option: DRAW_ARB_CLEAR_ON_RESET_EN adds a black full-screen sweep after reset.
module draw_port_arbiter
    import pong_draw_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int MAX_BURST = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [X_W*NUM_REQ-1:0]       x_in,
    input  logic [Y_W*NUM_REQ-1:0]       y_in,
    input  logic [COLOUR_W*NUM_REQ-1:0]  colour_in,
    output logic [NUM_REQ-1:0]           grant,
    output logic [X_W-1:0]               vga_x,
    output logic [Y_W-1:0]               vga_y,
    output logic [COLOUR_W-1:0]          vga_colour,
    output logic                         vga_plot,
    output logic                         busy
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST) + 1;
`ifdef DRAW_ARB_CLEAR_ON_RESET_EN
    localparam logic [1:0] RST_STATE = ST_CLEAR;
    logic [X_W-1:0] cx;
    logic [Y_W-1:0] cy;
`else
    localparam logic [1:0] RST_STATE = ST_IDLE;
`endif
    logic [1:0] state;
    logic [IW-1:0] last_owner, owner, pick;
    logic found, acc, in_range, last_px;
    logic [BW-1:0] burst_cnt;
    logic [X_W-1:0] sx;
    logic [Y_W-1:0] sy;
    logic [COLOUR_W-1:0] sc;

    draw_rr_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
        .req(req), .last_owner(last_owner), .found(found), .index(pick)
    );

    assign sx = x_in[X_W*int'(owner) +: X_W];
    assign sy = y_in[Y_W*int'(owner) +: Y_W];
    assign sc = colour_in[COLOUR_W*int'(owner) +: COLOUR_W];
    assign acc = (state == ST_OWN) && req[owner];
    assign in_range = (sx < X_W'(SCREEN_W)) && (sy < Y_W'(SCREEN_H));
    assign last_px = burst_cnt == BW'(MAX_BURST - 1);
    assign busy = state != ST_IDLE;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RST_STATE;
            grant <= '0;
            vga_plot <= 1'b0;
            vga_x <= '0;
            vga_y <= '0;
            vga_colour <= '0;
            last_owner <= IW'(NUM_REQ - 1);
            owner <= '0;
            burst_cnt <= '0;
`ifdef DRAW_ARB_CLEAR_ON_RESET_EN
            cx <= '0;
            cy <= '0;
`endif
        end else if (state == ST_IDLE) begin
            vga_plot <= 1'b0;
            if (found) begin
                state <= ST_OWN;
                grant <= NUM_REQ'(1) << pick;
                owner <= pick;
                burst_cnt <= '0;
            end
        end else if (state == ST_OWN) begin
            // Out-of-range pixels are consumed (counted) but never reach the adapter.
            vga_plot <= acc && in_range;
            if (acc && in_range) begin
                vga_x <= sx;
                vga_y <= sy;
                vga_colour <= sc;
            end
            if (acc)
                burst_cnt <= (&burst_cnt) ? burst_cnt : burst_cnt + 1'b1;
            if (!acc || last_px) begin
                state <= ST_IDLE;
                grant <= '0;
                last_owner <= owner;
            end
        end
`ifdef DRAW_ARB_CLEAR_ON_RESET_EN
        else begin
            vga_plot <= 1'b1;
            vga_x <= cx;
            vga_y <= cy;
            vga_colour <= COLOUR_BLACK;
            cx <= (cx == X_W'(SCREEN_W - 1)) ? '0 : cx + 1'b1;
            cy <= (cx == X_W'(SCREEN_W - 1)) ? cy + 1'b1 : cy;
            if (cx == X_W'(SCREEN_W - 1) && cy == Y_W'(SCREEN_H - 1))
                state <= ST_IDLE;
        end
`endif
    end
endmodule

// File: tb/tb_draw_port_arbiter.sv
// tb_draw_port_arbiter: directed and random stimulus checked against a pixel-stream reference model
module tb_draw_port_arbiter;
    localparam int N = 3;
    localparam int MB = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [N-1:0] req = '0;
    logic [8*N-1:0] x_in;
    logic [7*N-1:0] y_in;
    logic [3*N-1:0] colour_in;
    logic [N-1:0] grant;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic vga_plot, busy;

    draw_port_arbiter #(.NUM_REQ(N), .MAX_BURST(MB)) dut (
        .clock(clock), .reset(reset), .req(req), .x_in(x_in), .y_in(y_in),
        .colour_in(colour_in), .grant(grant), .vga_x(vga_x), .vga_y(vga_y),
        .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy)
    );

    always #5 clock = ~clock;

    int px_x[N], px_y[N], px_c[N];
    int vectors = 0, miscompares = 0;
    // reference model: who owns the port, how many pixels it has sent, what the adapter should see
    bit m_own;
    int m_owner, m_sent, m_last, m_acc;
    int e_x, e_y, e_c;
    bit e_plot;
    int seq_x[3] = '{160, 20, 159};
    int seq_y[3] = '{50, 120, 119};

    task automatic model(input logic [N-1:0] r, input bit rst);
        m_acc = -1;
        if (rst) begin
            m_own = 0; m_last = N - 1; m_sent = 0;
            e_plot = 0; e_x = 0; e_y = 0; e_c = 0;
        end else if (!m_own) begin
            e_plot = 0;
            for (int k = 1; k <= N; k++)
                if (!m_own && r[(m_last + k) % N]) begin
                    m_own = 1; m_owner = (m_last + k) % N; m_sent = 0;
                end
        end else if (r[m_owner]) begin
            m_acc = m_owner;
            m_sent++;
            e_plot = px_x[m_owner] < 160 && px_y[m_owner] < 120;
            if (e_plot) begin
                e_x = px_x[m_owner]; e_y = px_y[m_owner]; e_c = px_c[m_owner];
            end
            if (m_sent == MB) begin m_own = 0; m_last = m_owner; end
        end else begin
            e_plot = 0; m_own = 0; m_last = m_owner;
        end
    endtask

    task automatic step(input logic [N-1:0] r, input bit rst, input string tag);
        logic [N+20:0] got, exp;
        req = r;
        reset = rst;
        for (int i = 0; i < N; i++) begin
            x_in[8*i+:8] = 8'(px_x[i]);
            y_in[7*i+:7] = 7'(px_y[i]);
            colour_in[3*i+:3] = 3'(px_c[i]);
        end
        model(r, rst);
        @(posedge clock);
        #1;
        got = {grant, vga_plot, vga_x, vga_y, vga_colour, busy};
        exp = {m_own ? N'(1) << m_owner : N'(0), e_plot, 8'(e_x), 7'(e_y), 3'(e_c), m_own};
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got grant/plot/x/y/c/busy=%h expected %h", tag, got, exp);
        end
    endtask

    task automatic new_pixel(input int i, input bit wide);
        px_x[i] = $urandom_range(0, wide ? 175 : 159);
        px_y[i] = $urandom_range(0, wide ? 127 : 119);
        px_c[i] = $urandom_range(0, 7);
    endtask

    initial begin
        int n;
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) new_pixel(i, 0);
        step('0, 1, "reset");
        step('0, 1, "reset");
        step('0, 0, "idle");
        // single requester streaming (10..14,119)
        px_x[0] = 10; px_y[0] = 119; px_c[0] = 5;
        n = 0;
        for (int k = 0; k < 9; k++) begin
            step(n < 5 ? 3'b001 : 3'b000, 0, "single");
            if (m_acc == 0) begin n++; px_x[0]++; end
        end
        // early release: requester 1 drops after two pixels, requester 2 waiting
        n = 0;
        for (int k = 0; k < 8; k++) begin
            step(n < 2 ? 3'b110 : 3'b100, 0, "release");
            if (m_acc >= 0) begin
                if (m_acc == 1) n++;
                new_pixel(m_acc, 0);
            end
        end
        step('0, 0, "release");
        // round robin with all requesters held
        for (int k = 0; k < 24; k++) begin
            step(3'b111, 0, "rr");
            if (m_acc >= 0) new_pixel(m_acc, 0);
        end
        for (int k = 0; k < 3; k++) step('0, 0, "rr");
        // out-of-range pixels consumed without plotting
        px_x[2] = seq_x[0]; px_y[2] = seq_y[0]; px_c[2] = 3;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            step(n < 3 ? 3'b100 : 3'b000, 0, "range");
            if (m_acc == 2) begin
                n++;
                if (n < 3) begin px_x[2] = seq_x[n]; px_y[2] = seq_y[n]; end
            end
        end
        // reset during third pixel of a burst
        n = 0;
        for (int k = 0; k < 6 && n < 2; k++) begin
            step(3'b111, 0, "midburst");
            if (m_acc >= 0) begin n++; new_pixel(m_acc, 0); end
        end
        step(3'b111, 1, "midreset");
        for (int k = 0; k < 6; k++) begin
            step(3'b111, 0, "postreset");
            if (m_acc >= 0) new_pixel(m_acc, 0);
        end
        // random traffic, occasional reset, some out-of-range pixels
        r = '0;
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 9) < 3) r[i] = ~r[i];
            step(r, $urandom_range(0, 199) == 0, "random");
            if (m_acc >= 0) new_pixel(m_acc, 1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
